// File: rtl/axi_stream_packetizer.sv
// AXI4-Stream Tx packetizer: turns a packet descriptor plus a plain
// valid/ready word stream into registered TDATA/TKEEP/TSTRB/TLAST beats
// tagged with the descriptor's TID/TDEST/TUSER.

// One byte lane: decides whether its byte is kept on this beat and zeroes it if not.
module axi_stream_packetizer_lane #(
  parameter int Idx      = 0,
  parameter int LenWidth = 16
) (
  input  logic [LenWidth-1:0] remaining,
  input  logic                last_beat,
  input  logic [7:0]          byte_in,
  output logic                keep,
  output logic [7:0]          byte_out
);
  // Non-final beats keep every lane; the final beat keeps lanes below the byte count.
  always_comb begin
    keep     = !last_beat || (LenWidth'(Idx) < remaining);
    byte_out = keep ? byte_in : 8'h00;
  end
endmodule

module axi_stream_packetizer #(
  parameter int DataWidth = 64,
  parameter int IdWidth   = 1,
  parameter int DestWidth = 1,
  parameter int UserWidth = 1,
  parameter int LenWidth  = 16,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [LenWidth-1:0]  desc_len_i,
  input  logic [IdWidth-1:0]   desc_id_i,
  input  logic [DestWidth-1:0] desc_dest_i,
  input  logic [UserWidth-1:0] desc_user_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 tvalid_o,
  input  logic                 tready_i,
  output logic [DataWidth-1:0] tdata_o,
  output logic [StrbWidth-1:0] tstrb_o,
  output logic [StrbWidth-1:0] tkeep_o,
  output logic                 tlast_o,
  output logic [IdWidth-1:0]   tid_o,
  output logic [DestWidth-1:0] tdest_o,
  output logic [UserWidth-1:0] tuser_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DestWidth-1:0] dest;
    logic [UserWidth-1:0] user;
  } desc_t;

  localparam logic [LenWidth-1:0] StrbLen = LenWidth'(StrbWidth);

  state_e                         state_q, state_d;
  desc_t                          desc_q;
  logic [LenWidth-1:0]            remaining_q;
  logic                           load;
  logic                           last_beat;
  logic [StrbWidth-1:0]           keep_d;
  logic [StrbWidth-1:0][7:0]      data_d;

  // Final beat is chosen by remaining <= StrbWidth, so the subtraction below never wraps.
  assign last_beat = (remaining_q <= StrbLen);
  assign load      = data_valid_i && data_ready_o;
  assign busy_o    = (state_q == BODY) || tvalid_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: a descriptor opens a packet, loading its final word closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (desc_valid_i)        state_d = BODY;
      BODY:    if (load && last_beat)   state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Handshake outputs: take words only when the output register is free or draining
  always_comb begin
    desc_ready_o = (state_q == IDLE);
    data_ready_o = (state_q == BODY) && (!tvalid_o || tready_i);
  end

  // Descriptor capture and remaining-byte countdown
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desc_q      <= '0;
      remaining_q <= '0;
    end else if (state_q == IDLE && desc_valid_i) begin
      desc_q      <= '{id: desc_id_i, dest: desc_dest_i, user: desc_user_i};
      remaining_q <= desc_len_i;
    end else if (load && !last_beat) begin
      remaining_q <= remaining_q - StrbLen;
    end
  end

  for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
    axi_stream_packetizer_lane #(.Idx(i), .LenWidth(LenWidth)) u_lane (
      .remaining (remaining_q),
      .last_beat (last_beat),
      .byte_in   (data_i[8*i +: 8]),
      .keep      (keep_d[i]),
      .byte_out  (data_d[i])
    );
  end

  // Output register: a load wins over a drain, so a handshake plus load gives back-to-back beats
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tvalid_o <= 1'b0;
      tdata_o  <= '0;
      tkeep_o  <= '0;
      tstrb_o  <= '0;
      tlast_o  <= 1'b0;
      tid_o    <= '0;
      tdest_o  <= '0;
      tuser_o  <= '0;
    end else if (load) begin
      tvalid_o <= 1'b1;
      tdata_o  <= data_d;
      tkeep_o  <= keep_d;
      tstrb_o  <= keep_d;
      tlast_o  <= last_beat;
      tid_o    <= desc_q.id;
      tdest_o  <= desc_q.dest;
      tuser_o  <= desc_q.user;
    end else if (tready_i) begin
      tvalid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_stream_packetizer.sv
// Randomized bench for axi_stream_packetizer (32-bit data, 4 byte lanes).
// A per-packet model turns each accepted word into the beat it must produce.
module tb_axi_stream_packetizer;
  localparam int DW = 32, SW = 4, IW = 2, LW = 16;

  logic          clk_i = 1'b0, rst_ni;
  logic          desc_valid_i, desc_ready_o;
  logic [LW-1:0] desc_len_i;
  logic [IW-1:0] desc_id_i, desc_dest_i, desc_user_i;
  logic          data_valid_i, data_ready_o;
  logic [DW-1:0] data_i;
  logic          tvalid_o, tready_i, tlast_o, busy_o;
  logic [DW-1:0] tdata_o;
  logic [SW-1:0] tstrb_o, tkeep_o;
  logic [IW-1:0] tid_o, tdest_o, tuser_o;

  axi_stream_packetizer #(.DataWidth(DW), .IdWidth(IW), .DestWidth(IW),
                          .UserWidth(IW), .LenWidth(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_len_i(desc_len_i),
    .desc_id_i(desc_id_i), .desc_dest_i(desc_dest_i), .desc_user_i(desc_user_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .tvalid_o(tvalid_o), .tready_i(tready_i), .tdata_o(tdata_o), .tstrb_o(tstrb_o),
    .tkeep_o(tkeep_o), .tlast_o(tlast_o), .tid_o(tid_o), .tdest_o(tdest_o),
    .tuser_o(tuser_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {int len; logic [IW-1:0] id, dest, user;} pkt_t;
  typedef struct {logic [DW-1:0] data; logic [SW-1:0] keep; logic last;
                  logic [IW-1:0] id, dest, user;} beat_t;

  pkt_t  pkt_q[$];
  beat_t exp_q[$];
  int    desc_cyc[$], word_cyc[$], beat_cyc[$];
  logic [SW-1:0] last_keep;
  int    total_bytes;

  task automatic add_pkt(input int len, input int id, input int dest, input int user);
    pkt_t p;
    p.len = len; p.id = IW'(id); p.dest = IW'(dest); p.user = IW'(user);
    pkt_q.push_back(p);
  endtask

  // Drives descriptors/words/tready and checks every cycle against the packet model.
  task automatic run(input int desc_pct, input int vld_pct, input int rdy_pct,
                     input int stall_at, input int stall_len, input int stop_beats,
                     input int max_cyc);
    pkt_t cur;
    beat_t e;
    int words_left = 0, beat_idx = 0, beats_done = 0, stall_left = stall_len;
    int rem, cnt;
    bit done = 0, prev_hold = 0;
    logic [DW+2*SW+1+3*IW-1:0] prev_pl, cur_pl;
    desc_cyc.delete(); word_cyc.delete(); beat_cyc.delete();
    total_bytes = 0;
    for (int c = 0; c < max_cyc; c++) begin
      desc_valid_i = (pkt_q.size() > 0) && ($urandom_range(99) < desc_pct);
      if (desc_valid_i) begin
        desc_len_i = LW'(pkt_q[0].len); desc_id_i = pkt_q[0].id;
        desc_dest_i = pkt_q[0].dest; desc_user_i = pkt_q[0].user;
      end
      data_valid_i = ($urandom_range(99) < vld_pct);
      data_i = $urandom;
      if (stall_left > 0 && tvalid_o && beats_done == stall_at) begin
        tready_i = 1'b0; stall_left--;
      end else tready_i = ($urandom_range(99) < rdy_pct);
      @(negedge clk_i);
      cur_pl = {tdata_o, tkeep_o, tstrb_o, tlast_o, tid_o, tdest_o, tuser_o};
      if (prev_hold) begin
        tests++;
        if (!tvalid_o || cur_pl !== prev_pl) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b pl=%h, want valid=1 pl=%h", tvalid_o, cur_pl, prev_pl);
        end
      end
      tests++;
      if (desc_ready_o !== (words_left == 0)) begin
        fails++; $display("FAIL desc_ready: got %b want %b", desc_ready_o, words_left == 0);
      end
      tests++;
      if (data_ready_o !== (words_left > 0 && (!tvalid_o || tready_i))) begin
        fails++; $display("FAIL data_ready: got %b want %b", data_ready_o,
                          words_left > 0 && (!tvalid_o || tready_i));
      end
      tests++;
      if (busy_o !== (words_left > 0 || tvalid_o)) begin
        fails++; $display("FAIL busy: got %b want %b", busy_o, words_left > 0 || tvalid_o);
      end
      if (tvalid_o && tready_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL extra_beat: got beat data=%h, want none", tdata_o);
        end else begin
          e = exp_q.pop_front();
          if (cur_pl !== {e.data, e.keep, e.keep, e.last, e.id, e.dest, e.user}) begin
            fails++;
            $display("FAIL beat%0d: got data=%h keep=%h strb=%h last=%b id=%0d dest=%0d user=%0d, want data=%h keep=%h last=%b id=%0d dest=%0d user=%0d",
                     beats_done, tdata_o, tkeep_o, tstrb_o, tlast_o, tid_o, tdest_o, tuser_o,
                     e.data, e.keep, e.last, e.id, e.dest, e.user);
          end
        end
        beat_cyc.push_back(cyc);
        beats_done++;
        last_keep = tkeep_o;
        total_bytes += $countones(tkeep_o);
      end
      if (data_valid_i && data_ready_o) begin
        tests++;
        if (words_left == 0) begin
          fails++; $display("FAIL stray_word: got word %h consumed, want not consumed", data_i);
        end else begin
          rem = cur.len - SW * beat_idx;
          cnt = (rem > SW) ? SW : rem;
          e.keep = SW'((1 << cnt) - 1);
          for (int b = 0; b < SW; b++) e.data[8*b +: 8] = e.keep[b] ? data_i[8*b +: 8] : 8'h00;
          e.last = (words_left == 1);
          e.id = cur.id; e.dest = cur.dest; e.user = cur.user;
          exp_q.push_back(e);
          words_left--; beat_idx++;
          word_cyc.push_back(cyc);
        end
      end
      if (desc_valid_i && desc_ready_o) begin
        cur = pkt_q.pop_front();
        words_left = (cur.len == 0) ? 1 : (cur.len + SW - 1) / SW;
        beat_idx = 0;
        desc_cyc.push_back(cyc);
      end
      prev_hold = tvalid_o && !tready_i;
      prev_pl = cur_pl;
      done = (stop_beats > 0) ? (beats_done >= stop_beats)
                              : (pkt_q.size() == 0 && words_left == 0 && exp_q.size() == 0);
      @(posedge clk_i); #1;
      if (done) break;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL timeout: got %0d beats pending after %0d cycles, want 0", exp_q.size(), max_cyc);
    end
    desc_valid_i = 1'b0; data_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if ({tvalid_o, tdata_o, tkeep_o, tstrb_o, tlast_o, tid_o, tdest_o, tuser_o,
         data_ready_o, busy_o, desc_ready_o} !== {1'b0, {DW{1'b0}}, {2*SW{1'b0}}, 1'b0,
         {3*IW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL %s: got valid=%b data=%h keep=%h strb=%h last=%b id/dest/user=%0d/%0d/%0d dr=%b busy=%b descr=%b, want all 0 with desc_ready=1",
               tag, tvalid_o, tdata_o, tkeep_o, tstrb_o, tlast_o, tid_o, tdest_o, tuser_o,
               data_ready_o, busy_o, desc_ready_o);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; desc_valid_i = 0; data_valid_i = 0; tready_i = 0;
    desc_len_i = '0; desc_id_i = '0; desc_dest_i = '0; desc_user_i = '0; data_i = '0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset_state");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic;
    add_pkt(10, 1, 2, 3);
    run(100, 100, 100, -1, 0, 0, 100);
    tests++;
    if (beat_cyc.size() != 3 || word_cyc.size() != 3) begin
      fails++; $display("FAIL basic_count: got %0d beats %0d words, want 3 3", beat_cyc.size(), word_cyc.size());
    end else begin
      tests++;
      if (beat_cyc[1] - beat_cyc[0] != 1 || beat_cyc[2] - beat_cyc[1] != 1) begin
        fails++; $display("FAIL basic_consecutive: got gaps %0d %0d, want 1 1",
                          beat_cyc[1] - beat_cyc[0], beat_cyc[2] - beat_cyc[1]);
      end
      tests++;
      if (word_cyc[0] - desc_cyc[0] != 1 || beat_cyc[0] - desc_cyc[0] != 2) begin
        fails++; $display("FAIL basic_latency: got word +%0d beat +%0d, want +1 +2",
                          word_cyc[0] - desc_cyc[0], beat_cyc[0] - desc_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    add_pkt(8, 2, 1, 0);
    add_pkt(4, 3, 3, 1);
    run(100, 100, 100, -1, 0, 0, 100);
    tests++;
    if (beat_cyc.size() != 3 || desc_cyc.size() != 2) begin
      fails++; $display("FAIL b2b_count: got %0d beats %0d descs, want 3 2", beat_cyc.size(), desc_cyc.size());
    end else begin
      tests++;
      if (beat_cyc[1] - beat_cyc[0] != 1 || beat_cyc[2] - beat_cyc[1] != 2) begin
        fails++; $display("FAIL b2b_bubble: got gaps %0d %0d, want 1 2",
                          beat_cyc[1] - beat_cyc[0], beat_cyc[2] - beat_cyc[1]);
      end
      tests++;
      if (desc_cyc[1] - word_cyc[1] != 1) begin
        fails++; $display("FAIL b2b_desc_ready: got +%0d, want +1", desc_cyc[1] - word_cyc[1]);
      end
    end
  endtask

  task automatic test_zero_len;
    add_pkt(0, 1, 1, 1);
    run(100, 100, 100, -1, 0, 0, 100);
    tests++;
    if (word_cyc.size() != 1 || beat_cyc.size() != 1 || last_keep !== 4'h0) begin
      fails++; $display("FAIL zero_len: got %0d words %0d beats keep=%h, want 1 1 0",
                        word_cyc.size(), beat_cyc.size(), last_keep);
    end
    tests++;
    if (desc_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL zero_len_idle: got desc_ready=%b busy=%b, want 1 0", desc_ready_o, busy_o);
    end
  endtask

  task automatic test_stall;
    add_pkt(16, 0, 2, 1);
    run(100, 100, 100, 1, 5, 0, 100);
    tests++;
    if (beat_cyc.size() != 4) begin
      fails++; $display("FAIL stall_count: got %0d beats, want 4", beat_cyc.size());
    end else begin
      tests++;
      if (beat_cyc[1] - beat_cyc[0] != 6 || beat_cyc[2] - beat_cyc[1] != 1 ||
          beat_cyc[3] - beat_cyc[2] != 1) begin
        fails++; $display("FAIL stall_timing: got gaps %0d %0d %0d, want 6 1 1",
                          beat_cyc[1] - beat_cyc[0], beat_cyc[2] - beat_cyc[1], beat_cyc[3] - beat_cyc[2]);
      end
    end
  endtask

  task automatic test_random;
    int sum = 0;
    for (int i = 0; i < 10; i++) begin
      int l = $urandom_range(40);
      sum += l;
      add_pkt(l, $urandom_range(3), $urandom_range(3), $urandom_range(3));
    end
    run(60, 70, 60, -1, 0, 0, 3000);
    tests++;
    if (total_bytes != sum) begin
      fails++; $display("FAIL random_bytes: got %0d, want %0d", total_bytes, sum);
    end
  endtask

  task automatic test_reset_mid;
    add_pkt(16, 3, 0, 2);
    run(100, 100, 100, -1, 0, 2, 100);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    pkt_q.delete(); exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    add_pkt(4, 1, 2, 3);
    run(100, 100, 100, -1, 0, 0, 100);
    tests++;
    if (beat_cyc.size() != 1 || last_keep !== 4'hF) begin
      fails++; $display("FAIL reset_recover: got %0d beats keep=%h, want 1 F", beat_cyc.size(), last_keep);
    end
  endtask

  task automatic test_long;
    add_pkt(65535, 2, 1, 3);
    run(100, 90, 75, -1, 0, 0, 60000);
    tests++;
    if (beat_cyc.size() != 16384 || last_keep !== 4'h7 || total_bytes != 65535) begin
      fails++; $display("FAIL long: got %0d beats keep=%h bytes=%0d, want 16384 7 65535",
                        beat_cyc.size(), last_keep, total_bytes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_len();
    test_stall();
    test_random();
    test_reset_mid();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
